// File: rtl/bus_pkg.sv
// Shared system-bus definitions: fixed addresses, open-bus value, DMA state
// encoding and the request bundle that every BUS_* master drives.
package bus_pkg;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;
    localparam logic [7:0]  OPEN_BUS = 8'hFF;
    localparam logic [3:0]  TIMEOUT  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } dma_state_t;

    // Access protocol shared by all BUS_* slaves: the master holds this bundle
    // stable until Finish is sampled high; a slave accepts on the edge where cmd
    // is sampled, pulses Finish the following cycle and re-arms one cycle later.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        cmd;
        logic        rw;
    } bus_req_t;

endpackage

// File: rtl/bus_timeout.sv
// Per-access watchdog: pulses expire when a request has waited TIMEOUT cycles
// without a Finish, so an unmapped address cannot hang the bus.
module bus_timeout
    import bus_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic cmd,
    input  logic finish,
    output logic expire
);

    logic [3:0] count;
    logic [3:0] base;

    // A state change restarts the count even if cmd stays high across it.
    assign base   = start ? 4'd0 : count;
    assign expire = cmd && !finish && !start && (count == TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (cmd && !finish && !expire) begin
            count <= base + 4'd1;
        end else begin
            count <= 4'd0;
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// CPU-to-system-bus bridge: transparent pass-through when idle, and a 256-byte
// page copy into OAM ($2004) with the CPU stalled when $4014 is written.
module oam_dma_ctrl
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] c_Addr,
    input  logic [7:0]  c_WData,
    output logic [7:0]  c_RData,
    input  logic        c_Cmd,
    input  logic        c_RW,
    output logic        c_Finish,
    output logic [15:0] m_Addr,
    output logic [7:0]  m_WData,
    input  logic [7:0]  m_RData,
    output logic        m_Cmd,
    output logic        m_RW,
    input  logic        m_Finish,
    output logic        dma_busy,
    output logic        dma_err
);

    dma_state_t state;
    dma_state_t prev_state;
    bus_req_t   dma_req;
    logic [7:0] page;
    logic [7:0] idx;
    logic       ack_finish;
    logic       busy;
    logic       err;
    logic       trigger;
    logic       pass;
    logic       expire;
    logic       done;
    logic [7:0] rdata_eff;

    assign trigger   = c_Cmd && c_RW && (c_Addr == DMA_REG);
    assign pass      = rst_n && (state == IDLE) && c_Cmd && !trigger;
    assign done      = m_Finish || expire;
    assign rdata_eff = m_Finish ? m_RData : OPEN_BUS;

    // Idle traffic is combinational; DMA traffic comes from registers.
    assign m_Cmd    = pass ? 1'b1    : dma_req.cmd;
    assign m_RW     = pass ? c_RW    : dma_req.rw;
    assign m_Addr   = pass ? c_Addr  : dma_req.addr;
    assign m_WData  = pass ? c_WData : dma_req.wdata;
    assign c_Finish = pass ? done    : ack_finish;
    assign c_RData  = pass ? (expire ? OPEN_BUS : m_RData) : 8'h00;
    assign dma_busy = busy;
    assign dma_err  = err;

    bus_timeout u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (state != prev_state),
        .cmd    (m_Cmd),
        .finish (m_Finish),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_state <= IDLE;
            dma_req    <= '0;
            page       <= 8'h00;
            idx        <= 8'h00;
            ack_finish <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            prev_state <= state;
            ack_finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page       <= c_WData;
                        idx        <= 8'h00;
                        err        <= 1'b0;
                        ack_finish <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ACK;
                    end else if (pass && expire) begin
                        err <= 1'b1;
                    end
                end
                ACK: begin
                    dma_req <= '{addr: {page, 8'h00}, wdata: 8'h00, cmd: 1'b1, rw: 1'b0};
                    state   <= RD;
                end
                RD: begin
                    if (done) begin
                        dma_req <= '{addr: OAM_DATA, wdata: rdata_eff, cmd: 1'b1, rw: 1'b1};
                        if (expire) begin
                            err <= 1'b1;
                        end
                        state <= WR;
                    end
                end
                WR: begin
                    if (done) begin
                        if (expire) begin
                            err <= 1'b1;
                        end
                        if (idx == 8'hFF) begin
                            dma_req <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            idx     <= idx + 8'd1;
                            dma_req <= '{addr: {page, idx + 8'd1}, wdata: 8'h00, cmd: 1'b1, rw: 1'b0};
                            state   <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
